// File: rtl/axilite_pkg.sv
// Shared AXI-lite definitions: response codes and the read-arbiter state encoding.
package axilite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: starting just above the last winner and
// wrapping around, returns the first requester. Shared by read and write arbiters.
module rr_pick #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] pick,
    output logic          any_req
);

    // Walk last+1 .. last+N (mod N); the first set bit wins and later hits are ignored
    always_comb begin
        int  j;
        logic found;
        j       = 0;
        found   = 1'b0;
        pick    = {IW{1'b0}};
        for (int k = 1; k <= N; k++) begin
            j     = (int'(last) + k) % N;
            pick  = (!found && req[j]) ? IW'(j) : pick;
            found = found | req[j];
        end
        any_req = |req;
    end

endmodule

// File: rtl/axilite_read_arbiter.sv
// Round-robin arbiter sharing one AXI-lite read slave between NUM_MASTERS masters.
// One transaction in flight; the grant is held from arbitration through the R handshake.
module axilite_read_arbiter
    import axilite_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int ADDR_SIZE   = 32,
    parameter  int DATA_WIDTH  = 32,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS*ADDR_SIZE-1:0]  m_araddr,
    input  logic [NUM_MASTERS-1:0]            m_arvalid,
    output logic [NUM_MASTERS-1:0]            m_arready,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS*2-1:0]          m_rresp,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    input  logic [NUM_MASTERS-1:0]            m_rready,
    output logic [ADDR_SIZE-1:0]              s_araddr,
    output logic                              s_arvalid,
    input  logic                              s_arready,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    input  logic [1:0]                        s_rresp,
    input  logic                              s_rvalid,
    output logic                              s_rready,
    output logic [IDX_W-1:0]                  grant,
    output logic                              busy
);

    logic [1:0]       state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick;
    logic             any_req;

    rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req     (m_arvalid),
        .last    (last_grant),
        .pick    (pick),
        .any_req (any_req)
    );

    assign busy = (state != ST_IDLE);

    // Arbitration FSM: latch the winner in IDLE, advance on AR then R handshakes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant      <= {IDX_W{1'b0}};
            last_grant <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant      <= pick;
                        last_grant <= pick;
                        state      <= ST_ADDR;
                    end else begin
                        state      <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (s_arvalid && s_arready) begin
                        state <= ST_DATA;
                    end else begin
                        state <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (s_rvalid && s_rready) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Channel routing: only the granted master is connected, everything else reads 0
    always_comb begin
        m_arready = {NUM_MASTERS{1'b0}};
        m_rvalid  = {NUM_MASTERS{1'b0}};
        m_rdata   = {(NUM_MASTERS*DATA_WIDTH){1'b0}};
        m_rresp   = {(NUM_MASTERS*2){1'b0}};
        s_araddr  = {ADDR_SIZE{1'b0}};
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        case (state)
            ST_ADDR: begin
                s_araddr         = m_araddr[int'(grant)*ADDR_SIZE +: ADDR_SIZE];
                s_arvalid        = m_arvalid[grant];
                m_arready[grant] = s_arready;
            end
            ST_DATA: begin
                m_rvalid[grant]                                = s_rvalid;
                m_rdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH]  = s_rdata;
                m_rresp[int'(grant)*2 +: 2]                    = s_rresp;
                s_rready                                       = m_rready[grant];
            end
            default: begin
                s_arvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axilite_read_arbiter.sv
// Self-checking bench for axilite_read_arbiter with three masters.
module tb_axilite_read_arbiter;
    import axilite_pkg::*;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = $clog2(NM);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NM*AW-1:0] m_araddr = '0;
    logic [NM-1:0]    m_arvalid = '0;
    logic [NM-1:0]    m_arready;
    logic [NM*DW-1:0] m_rdata;
    logic [NM*2-1:0]  m_rresp;
    logic [NM-1:0]    m_rvalid;
    logic [NM-1:0]    m_rready = '0;
    logic [AW-1:0]    s_araddr;
    logic             s_arvalid;
    logic             s_arready = 1'b0;
    logic [DW-1:0]    s_rdata = '0;
    logic [1:0]       s_rresp = '0;
    logic             s_rvalid = 1'b0;
    logic             s_rready;
    logic [IW-1:0]    grant;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    int model_last = NM - 1;
    logic [AW-1:0] addr_of [NM];

    typedef struct {
        logic [NM-1:0] mask;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        int            exp_grant;
    } vec_t;

    vec_t vecs [11];

    axilite_read_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_SIZE   (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .grant     (grant),
        .busy      (busy)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference round robin: lowest requester above the last winner, else lowest overall.
    function automatic int model_pick(input logic [NM-1:0] mask, input int last);
        int best;
        best = -1;
        for (int i = NM - 1; i > last; i--) if (mask[i]) best = i;
        if (best < 0) begin
            for (int i = NM - 1; i >= 0; i--) if (mask[i]) best = i;
        end
        return best;
    endfunction

    task automatic apply_reset(input string tag);
        m_arvalid = '0;
        s_arready = 1'b0;
        rst = 1'b0;
        tick();
        check({tag, " rst busy/grant"}, {busy, grant}, 0);
        check({tag, " rst s_ar"}, {s_arvalid, s_araddr}, 0);
        check({tag, " rst s_rready"}, s_rready, 0);
        check({tag, " rst m_arready/m_rvalid"}, {m_arready, m_rvalid}, 0);
        check({tag, " rst m_rdata"}, m_rdata, 0);
        check({tag, " rst m_rresp"}, m_rresp, 0);
        rst = 1'b1;
        model_last = NM - 1;
    endtask

    // Raise requests, wait for the grant and complete the AR handshake; ends in DATA.
    task automatic go_data(input logic [NM-1:0] mask, input int exp_g, input int ar_wait,
                           input string tag, output int g);
        int n;
        for (int i = 0; i < NM; i++) m_araddr[i*AW +: AW] = addr_of[i];
        m_arvalid = mask;
        m_rready  = '1;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!busy && n < 8);
        check({tag, " granted"}, busy, 1);
        g = int'(grant);
        check({tag, " grant"}, grant, exp_g);
        check({tag, " s_araddr"}, s_araddr, addr_of[exp_g]);
        check({tag, " s_arvalid"}, s_arvalid, 1);
        check({tag, " addr quiet"}, {m_arready, m_rvalid, s_rready}, 0);
        repeat (ar_wait) tick();
        s_arready = 1'b1;
        #1;
        check({tag, " m_arready"}, m_arready, 128'd1 << exp_g);
        tick();
        s_arready = 1'b0;
        if (g < NM) m_arvalid[g] = 1'b0;
        model_last = exp_g;
        #1;
        check({tag, " in data"}, {busy, s_arvalid}, 2'b10);
    endtask

    // Slave returns one beat after r_wait idle cycles; checks routing and return to IDLE.
    task automatic finish_r(input logic [DW-1:0] data, input logic [1:0] resp, input int exp_g,
                            input int r_wait, input string tag);
        logic [NM*DW-1:0] exp_data;
        logic [NM*2-1:0]  exp_resp;
        repeat (r_wait) begin
            check({tag, " r wait"}, m_rvalid, 0);
            tick();
        end
        exp_data = '0;
        exp_resp = '0;
        exp_data[exp_g*DW +: DW] = data;
        exp_resp[exp_g*2 +: 2]   = resp;
        s_rvalid = 1'b1;
        s_rdata  = data;
        s_rresp  = resp;
        #1;
        check({tag, " m_rvalid"}, m_rvalid, 128'd1 << exp_g);
        check({tag, " m_rdata"}, m_rdata, exp_data);
        check({tag, " m_rresp"}, m_rresp, exp_resp);
        check({tag, " s_rready"}, {s_rready, m_arready}, {1'b1, {NM{1'b0}}});
        tick();
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = '0;
        m_arvalid = '0;
        #1;
        check({tag, " back idle"}, {busy, s_arvalid, m_rvalid}, 0);
    endtask

    task automatic run_txn(input logic [NM-1:0] mask, input logic [DW-1:0] data, input logic [1:0] resp,
                           input int exp_g, input int ar_wait, input int r_wait, input string tag);
        int g;
        go_data(mask, exp_g, ar_wait, tag, g);
        finish_r(data, resp, exp_g, r_wait, tag);
    endtask

    // Global time limit so a stuck DUT cannot hang the run
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "time limit");
    end

    // Main test sequence
    initial begin
        logic [NM-1:0] pending;
        int            waits [NM];
        int            g;
        int            e;

        addr_of[0] = 32'h0000_0008;
        addr_of[1] = 32'h0000_0004;
        addr_of[2] = 32'h0000_000C;

        vecs[0]  = '{3'b001, 32'hDEAD_BEEF, RESP_OKAY,   0};
        vecs[1]  = '{3'b011, 32'h1111_0001, RESP_OKAY,   1};
        vecs[2]  = '{3'b011, 32'h1111_0002, RESP_OKAY,   0};
        vecs[3]  = '{3'b011, 32'h1111_0003, RESP_EXOKAY, 1};
        vecs[4]  = '{3'b110, 32'h2222_0004, RESP_SLVERR, 2};
        vecs[5]  = '{3'b111, 32'h3333_0005, RESP_OKAY,   0};
        vecs[6]  = '{3'b010, 32'h4444_0006, RESP_SLVERR, 1};
        vecs[7]  = '{3'b101, 32'h5555_0007, RESP_DECERR, 2};
        vecs[8]  = '{3'b100, 32'h6666_0008, RESP_OKAY,   2};
        vecs[9]  = '{3'b011, 32'h7777_0009, RESP_DECERR, 0};
        vecs[10] = '{3'b101, 32'h8888_000A, RESP_EXOKAY, 2};

        repeat (2) tick();
        apply_reset("init");

        // Table: fixed request patterns with hand-derived winners
        for (int t = 0; t < 11; t++) begin
            run_txn(vecs[t].mask, vecs[t].data, vecs[t].resp, vecs[t].exp_grant,
                    t % 2, t % 3, $sformatf("vec%0d", t));
        end

        // Backpressure: m0 holds off rready for 5 cycles while m1 waits
        apply_reset("bp");
        go_data(3'b001, 0, 0, "bp", g);
        m_arvalid = 3'b010;
        m_rready  = 3'b110;
        s_rvalid  = 1'b1;
        s_rdata   = 32'hA5A5_0001;
        s_rresp   = RESP_OKAY;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp s_rready", s_rready, 0);
            check("bp hold", {busy, grant}, {1'b1, IW'(0)});
            check("bp m_rvalid", {m_rvalid, m_arready}, {3'b001, 3'b000});
            tick();
        end
        m_rready = 3'b111;
        #1;
        check("bp release", s_rready, 1);
        tick();
        s_rvalid = 1'b0;
        #1;
        check("bp idle", busy, 0);
        run_txn(3'b010, 32'hA5A5_0002, RESP_OKAY, 1, 0, 0, "bp next");

        // Reset in the middle of a DATA phase
        e = model_pick(3'b100, model_last);
        go_data(3'b100, e, 1, "rstd", g);
        s_rvalid = 1'b1;
        s_rdata  = 32'hFFFF_FFFF;
        s_rresp  = RESP_DECERR;
        apply_reset("rstd");
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_rresp  = '0;
        run_txn(3'b010, 32'hCAFE_0001, RESP_OKAY, 1, 0, 0, "rstd m1");
        apply_reset("rstd2");
        run_txn(3'b011, 32'hCAFE_0002, RESP_OKAY, 0, 0, 1, "rstd m0m1");

        // Random traffic: m2 always requesting, m0/m1 sporadic; compare with reference model
        pending = '0;
        for (int i = 0; i < NM; i++) waits[i] = 0;
        for (int t = 0; t < 40; t++) begin
            pending[2] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    waits[i]   = 0;
                end
            end
            e = model_pick(pending, model_last);
            go_data(pending, e, $urandom_range(0, 2), $sformatf("rnd%0d", t), g);
            finish_r($urandom, 2'($urandom_range(0, 3)), e, $urandom_range(0, 2), $sformatf("rnd%0d", t));
            for (int i = 0; i < NM; i++) if (pending[i] && i != g) waits[i]++;
            if (g < NM) begin
                check($sformatf("rnd%0d wait bound", t), waits[g] <= NM - 1, 1);
                waits[g]   = 0;
                pending[g] = 1'b0;
                addr_of[g] = $urandom;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
